// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: walks a 3-input gate through all 8 input rows, holds
// each row for a programmable settle time, captures the gate output per row
// and compares the captured table against an expected table.
// Optional feature: define SWEEP_GRAY_EN to drive rows in Gray order
// (000,001,011,010,110,111,101,100) instead of binary order.
module truth_table_sweeper #(
  parameter int SETTLE_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [7:0]          table_cfg,
  input  logic [SETTLE_W-1:0] settle,
  output logic [2:0]          dut_in,
  input  logic                dut_out,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [7:0]          obs_table,
  output logic [7:0]          mismatch
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t              state, state_n;
  logic [2:0]          row_r, row_n;
  logic [SETTLE_W-1:0] cnt_r, cnt_n;
  logic [SETTLE_W-1:0] s_r, s_n;
  logic [7:0]          exp_r, exp_n;
  logic [7:0]          obs_n;
  logic [7:0]          mis_n;
  logic                pass_n;
  logic                done_n;

  // Maps the sequential row index onto the input pattern actually driven.
  function automatic logic [2:0] row_code(input logic [2:0] r);
`ifdef SWEEP_GRAY_EN
    return r ^ (r >> 1);
`else
    return r;
`endif
  endfunction

  // Register every piece of sweep state; reset clears outputs immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      row_r     <= '0;
      cnt_r     <= '0;
      s_r       <= '0;
      exp_r     <= '0;
      obs_table <= '0;
      mismatch  <= '0;
      pass      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      row_r     <= row_n;
      cnt_r     <= cnt_n;
      s_r       <= s_n;
      exp_r     <= exp_n;
      obs_table <= obs_n;
      mismatch  <= mis_n;
      pass      <= pass_n;
      done      <= done_n;
    end
  end

  // Next-state logic: start latches config, HOLD counts settle cycles per row
  // and samples on the last one; the final sample produces the verdict.
  always_comb begin
    state_n = state;
    row_n   = row_r;
    cnt_n   = cnt_r;
    s_n     = s_r;
    exp_n   = exp_r;
    obs_n   = obs_table;
    mis_n   = mismatch;
    pass_n  = pass;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = HOLD;
          exp_n   = table_cfg;
          s_n     = (settle == '0) ? SETTLE_W'(1) : settle;
          obs_n   = '0;
          mis_n   = '0;
          pass_n  = 1'b0;
          row_n   = '0;
          cnt_n   = '0;
        end
      end
      HOLD: begin
        if (abort) begin
          state_n = IDLE;
          row_n   = '0;
          cnt_n   = '0;
          pass_n  = 1'b0;
        end else if (cnt_r == s_r - SETTLE_W'(1)) begin
          obs_n[3'd7 - row_code(row_r)] = dut_out;
          cnt_n = '0;
          if (row_r == 3'd7) begin
            state_n = IDLE;
            row_n   = '0;
            mis_n   = obs_n ^ exp_r;
            pass_n  = (mis_n == 8'h00);
            done_n  = 1'b1;
          end else begin
            row_n = row_r + 3'd1;
          end
        end else begin
          cnt_n = cnt_r + SETTLE_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Gate inputs are driven only while a sweep is holding a row.
  always_comb begin
    busy   = (state == HOLD);
    dut_in = (state == HOLD) ? row_code(row_r) : 3'b000;
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Testbench for truth_table_sweeper: a behavioural gate driven by a truth
// table variable, with expected results derived from the gate table and the
// row ordering rather than from the design's internal state.
module tb_truth_table_sweeper;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [7:0] table_cfg;
  logic [7:0] settle;
  logic [2:0] dut_in;
  logic       dut_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] obs_table;
  logic [7:0] mismatch;

  logic [7:0] gate_tt;

  int errors = 0;
  int checks = 0;

  logic [2:0] seen_in   [0:2100];
  logic       seen_busy [0:2100];
  int         seen_n;
  bit         timed_out;

  truth_table_sweeper #(.SETTLE_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .table_cfg (table_cfg),
    .settle    (settle),
    .dut_in    (dut_in),
    .dut_out   (dut_out),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .obs_table (obs_table),
    .mismatch  (mismatch)
  );

  // Free-running clock, 10 ns period.
  always #5 clk = ~clk;

  // Gate under characterisation: Cello bit order, row 000 is bit 7.
  assign dut_out = gate_tt[3'd7 - dut_in];

  // Input pattern expected for the r-th row of a sweep.
  function automatic logic [2:0] row_order(input int r);
    logic [2:0] gray_seq [0:7];
    int rr;
    gray_seq = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
    rr = r;
`ifdef SWEEP_GRAY_EN
    return gray_seq[rr[2:0]];
`else
    return rr[2:0];
`endif
  endfunction

  // Expected dut_in j cycles after the start edge for effective settle se.
  function automatic logic [2:0] exp_in(input int j, input int se);
    if (j < 8 * se) return row_order(j / se);
    return 3'b000;
  endfunction

  // Launch one sweep and record dut_in/busy after every edge until done.
  task automatic do_sweep(input logic [7:0] cfg, input logic [7:0] s,
                          input logic [7:0] cfg_after, input logic [7:0] s_after,
                          input logic abort_at_start);
    table_cfg = cfg;
    settle    = s;
    start     = 1'b1;
    abort     = abort_at_start;
    @(posedge clk); #1;
    start     = 1'b0;
    abort     = 1'b0;
    table_cfg = cfg_after;
    settle    = s_after;
    seen_n       = 0;
    seen_in[0]   = dut_in;
    seen_busy[0] = busy;
    timed_out    = 1'b0;
    while (done !== 1'b1) begin
      if (seen_n >= 2090) begin
        timed_out = 1'b1;
        break;
      end
      @(posedge clk); #1;
      seen_n++;
      seen_in[seen_n]   = dut_in;
      seen_busy[seen_n] = busy;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    table_cfg = 8'h00; settle = 8'd1; gate_tt = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (dut_in !== 3'b000) begin errors++; $display("[TB] FAIL reset_dut_in got=%b want=000", dut_in); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got=%b want=0", done); end
    checks++; if (pass !== 1'b0) begin errors++; $display("[TB] FAIL reset_pass got=%b want=0", pass); end
    checks++; if (obs_table !== 8'h00) begin errors++; $display("[TB] FAIL reset_obs got=%h want=00", obs_table); end
    checks++; if (mismatch !== 8'h00) begin errors++; $display("[TB] FAIL reset_mismatch got=%h want=00", mismatch); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    gate_tt = 8'h53;
    do_sweep(8'h53, 8'd4, 8'h53, 8'd4, 1'b0);
    checks++; if (timed_out || seen_n != 32) begin errors++; $display("[TB] FAIL basic_latency got=%0d want=32", seen_n); end
    checks++; if (obs_table !== 8'h53) begin errors++; $display("[TB] FAIL basic_obs got=%h want=53", obs_table); end
    checks++; if (mismatch !== 8'h00) begin errors++; $display("[TB] FAIL basic_mismatch got=%h want=00", mismatch); end
    checks++; if (pass !== 1'b1) begin errors++; $display("[TB] FAIL basic_pass got=%b want=1", pass); end
    for (int j = 0; j <= seen_n; j++) begin
      checks++;
      if (seen_in[j] !== exp_in(j, 4) || seen_busy[j] !== (j < 32)) begin
        errors++;
        $display("[TB] FAIL basic_seq cycle=%0d got in=%b busy=%b want in=%b busy=%b",
                 j, seen_in[j], seen_busy[j], exp_in(j, 4), (j < 32));
      end
    end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_pulse got=%b want=0", done); end
    checks++; if (pass !== 1'b1) begin errors++; $display("[TB] FAIL basic_pass_hold got=%b want=1", pass); end
  endtask

  task automatic test_stuck_row();
    gate_tt = 8'h53 | 8'h04;
    do_sweep(8'h53, 8'd4, 8'h53, 8'd4, 1'b0);
    checks++; if (timed_out || seen_n != 32) begin errors++; $display("[TB] FAIL stuck_latency got=%0d want=32", seen_n); end
    checks++; if (obs_table !== 8'h57) begin errors++; $display("[TB] FAIL stuck_obs got=%h want=57", obs_table); end
    checks++; if (mismatch !== 8'h04) begin errors++; $display("[TB] FAIL stuck_mismatch got=%h want=04", mismatch); end
    checks++; if (pass !== 1'b0) begin errors++; $display("[TB] FAIL stuck_pass got=%b want=0", pass); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    gate_tt = 8'hA5;
    do_sweep(8'hA5, 8'd0, 8'hA5, 8'd0, 1'b0);
    checks++; if (timed_out || seen_n != 8) begin errors++; $display("[TB] FAIL b2b_first_latency got=%0d want=8", seen_n); end
    checks++; if (pass !== 1'b1) begin errors++; $display("[TB] FAIL b2b_first_pass got=%b want=1", pass); end
    gate_tt = 8'h3C;
    do_sweep(8'h3C, 8'd0, 8'h3C, 8'd0, 1'b0);
    checks++; if (seen_busy[0] !== 1'b1) begin errors++; $display("[TB] FAIL b2b_restart_busy got=%b want=1", seen_busy[0]); end
    checks++; if (timed_out || seen_n != 8) begin errors++; $display("[TB] FAIL b2b_second_latency got=%0d want=8", seen_n); end
    checks++; if (obs_table !== 8'h3C) begin errors++; $display("[TB] FAIL b2b_obs got=%h want=3c", obs_table); end
    checks++; if (pass !== 1'b1) begin errors++; $display("[TB] FAIL b2b_pass got=%b want=1", pass); end
    for (int j = 0; j <= seen_n; j++) begin
      checks++;
      if (seen_in[j] !== exp_in(j, 1)) begin
        errors++;
        $display("[TB] FAIL b2b_seq cycle=%0d got=%b want=%b", j, seen_in[j], exp_in(j, 1));
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    int         k;
    bit         saw_done;
    logic [7:0] partial;
    logic [2:0] v;
    gate_tt   = 8'hFF;
    table_cfg = 8'h53;
    settle    = 8'd4;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (dut_in !== row_order(3) && k < 64) begin
      @(posedge clk); #1;
      k++;
    end
    checks++; if (k != 12) begin errors++; $display("[TB] FAIL abort_row3_time got=%0d want=12", k); end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    partial = 8'h00;
    for (int r = 0; r < 3; r++) begin
      v = row_order(r);
      partial[3'd7 - v] = gate_tt[3'd7 - v];
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy got=%b want=0", busy); end
    checks++; if (dut_in !== 3'b000) begin errors++; $display("[TB] FAIL abort_dut_in got=%b want=000", dut_in); end
    checks++; if (pass !== 1'b0) begin errors++; $display("[TB] FAIL abort_pass got=%b want=0", pass); end
    checks++; if (mismatch !== 8'h00) begin errors++; $display("[TB] FAIL abort_mismatch got=%h want=00", mismatch); end
    checks++; if (obs_table !== partial) begin errors++; $display("[TB] FAIL abort_partial_obs got=%h want=%h", obs_table, partial); end
    saw_done = 1'b0;
    repeat (40) begin
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (saw_done) begin errors++; $display("[TB] FAIL abort_quiet got=activity want=idle"); end
    gate_tt = 8'h0F;
    do_sweep(8'h0F, 8'd1, 8'h0F, 8'd1, 1'b1);
    checks++; if (timed_out || seen_n != 8) begin errors++; $display("[TB] FAIL abort_start_wins_latency got=%0d want=8", seen_n); end
    checks++; if (pass !== 1'b1) begin errors++; $display("[TB] FAIL abort_start_wins_pass got=%b want=1", pass); end
    @(posedge clk); #1;
  endtask

  task automatic test_cfg_change();
    gate_tt = 8'h96;
    do_sweep(8'h96, 8'd3, 8'h69, 8'd9, 1'b0);
    checks++; if (timed_out || seen_n != 24) begin errors++; $display("[TB] FAIL cfgchg_latency got=%0d want=24", seen_n); end
    checks++; if (obs_table !== 8'h96) begin errors++; $display("[TB] FAIL cfgchg_obs got=%h want=96", obs_table); end
    checks++; if (mismatch !== 8'h00) begin errors++; $display("[TB] FAIL cfgchg_mismatch got=%h want=00", mismatch); end
    checks++; if (pass !== 1'b1) begin errors++; $display("[TB] FAIL cfgchg_pass got=%b want=1", pass); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    gate_tt   = 8'hFF;
    table_cfg = 8'h00;
    settle    = 8'd2;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin
      errors++; $display("[TB] FAIL midrst_flags got busy=%b done=%b pass=%b want 0 0 0", busy, done, pass);
    end
    checks++; if (dut_in !== 3'b000 || obs_table !== 8'h00 || mismatch !== 8'h00) begin
      errors++; $display("[TB] FAIL midrst_data got in=%b obs=%h mis=%h want 000 00 00", dut_in, obs_table, mismatch);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_sweep(8'hFF, 8'd2, 8'hFF, 8'd2, 1'b0);
    checks++; if (timed_out || seen_n != 16) begin errors++; $display("[TB] FAIL midrst_sweep_latency got=%0d want=16", seen_n); end
    checks++; if (obs_table !== 8'hFF || pass !== 1'b1) begin
      errors++; $display("[TB] FAIL midrst_sweep_result got obs=%h pass=%b want ff 1", obs_table, pass);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [7:0] cfg;
    logic [7:0] s;
    int         se;
    for (int it = 0; it < 12; it++) begin
      cfg = 8'($urandom);
      case ($urandom_range(0, 2))
        0:       gate_tt = cfg;
        1:       gate_tt = cfg ^ (8'h01 << $urandom_range(0, 7));
        default: gate_tt = 8'($urandom);
      endcase
      s  = 8'($urandom_range(0, 5));
      se = (s == 8'd0) ? 1 : int'(s);
      do_sweep(cfg, s, 8'($urandom), 8'($urandom), 1'b0);
      checks++; if (timed_out || seen_n != 8 * se) begin errors++; $display("[TB] FAIL rand_latency it=%0d got=%0d want=%0d", it, seen_n, 8 * se); end
      checks++; if (obs_table !== gate_tt) begin errors++; $display("[TB] FAIL rand_obs it=%0d got=%h want=%h", it, obs_table, gate_tt); end
      checks++; if (mismatch !== (gate_tt ^ cfg)) begin errors++; $display("[TB] FAIL rand_mismatch it=%0d got=%h want=%h", it, mismatch, gate_tt ^ cfg); end
      checks++; if (pass !== (gate_tt == cfg)) begin errors++; $display("[TB] FAIL rand_pass it=%0d got=%b want=%b", it, pass, (gate_tt == cfg)); end
      for (int j = 0; j <= seen_n; j++) begin
        checks++;
        if (seen_in[j] !== exp_in(j, se)) begin
          errors++;
          $display("[TB] FAIL rand_seq it=%0d cycle=%0d got=%b want=%b", it, j, seen_in[j], exp_in(j, se));
        end
      end
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_basic();
    test_stuck_row();
    test_back_to_back();
    test_abort();
    test_cfg_change();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequencer that characterises one 3-input logic gate (Cello hex-named truth-table gate) by driving all 8 input rows and capturing the gate's output.
- Each row is held for a programmable settle time before sampling.
- Compares the captured 8-bit table against an expected table and reports pass/fail plus a per-row mismatch mask.
- Sits between a host/test controller and the gate under characterisation; one sweeper per gate instance.

Parameters:
- SETTLE_W, 8: width of the settle-time field; max hold = 2^SETTLE_W-1 cycles per row.

Ports:
- clk  input  1  single clock; all logic rising-edge.
- rst  input  1  reset, asynchronous and active-high.
- start  input  1  begin sweep; accepted only when busy=0.
- abort  input  1  cancel sweep in progress.
- table_cfg  input  8  expected table, Cello convention: bit 7 = row {in1,in2,in3}=000, bit 0 = row 111 (0x53 => rows 001,011,110,111 high).
- settle  input  SETTLE_W  cycles to hold each row; 0 treated as 1.
- dut_in  output  3  drives gate {in1,in2,in3}.
- dut_out  input  1  gate output; synchronous to clk, sampled directly.
- busy  output  1  sweep in progress.
- done  output  1  one-cycle pulse, sweep complete.
- pass  output  1  obs_table == expected; valid from done, held until next start.
- obs_table  output  8  captured table, same bit order as table_cfg.
- mismatch  output  8  obs_table XOR expected.

Behaviour:
- Reset: dut_in=000, busy=0, done=0, pass=0, obs_table=0, mismatch=0; FSM=IDLE; takes effect immediately, mid-sweep included; no done pulse is produced.
- FSM states:
  - IDLE: on start, latch table_cfg -> exp_r and S=max(settle,1); clear obs_table, mismatch, pass; row=0; go to HOLD.
  - HOLD: dut_in=row, counter counts S cycles. At the edge ending the S-th cycle (SAMPLE), write dut_out into obs_table bit (7-row).
    - If row<7: row+=1, stay in HOLD with counter reloaded; the next row is driven with no gap cycle.
    - If row==7: go to IDLE.
- Timing, with start sampled at edge E0:
  - busy=1 and dut_in=000 from E0.
  - Row r is driven on edges E0+r*S .. E0+(r+1)*S.
  - Final sample at E0+8S.
  - At E0+8S: busy->0, dut_in->000, done->1, mismatch=obs^exp_r, pass=(mismatch==0) (next-state values used).
  - Latency start->done = 8S cycles.
- done clears at the next edge.
- Start asserted in the done cycle is accepted (back-to-back sweeps).
- Start while busy: ignored.
- table_cfg/settle changes while busy: ignored (latched copies used).
- Abort while busy: next edge FSM=IDLE, busy=0, dut_in=000, no done pulse. obs_table holds partial captures; pass=0; mismatch unchanged (0).
- Abort in IDLE: no effect. Abort and start on the same edge in IDLE: start wins.
- Row counter 3 bits, no wrap past 7. Settle counter SETTLE_W bits, saturating-free reload.

Optional Feature:
- Macro SWEEP_GRAY_EN.
- Defined: rows are driven in Gray order 000,001,011,010,110,111,101,100, so only one input toggles per step. Each sample is still written to obs_table bit (7-row_value). Latency is unchanged.
- Undefined: binary order 000..111.

Test Plan:
- table_cfg=0x53, settle=4, correct gate model -> done 32 cycles after start, obs_table=0x53, mismatch=0x00, pass=1; dut_in steps 000..111 every 4 cycles.
- table_cfg=0x53, gate model with row 101 stuck at 1 -> obs_table=0x57, mismatch=0x04, pass=0.
- settle=0 -> treated as 1; done 8 cycles after start. Second start in the done cycle -> busy stays 1, next done 8 cycles later.
- Abort while row 3 is driven (settle=4) -> busy=0 and dut_in=000 next cycle; no done for 40 cycles; pass=0. Change table_cfg mid-sweep in a separate run -> result matches the table latched at start.
- Assert rst mid-sweep -> all outputs zero immediately; next start runs a full clean sweep.
- SWEEP_GRAY_EN defined, table_cfg=0x53, settle=2 -> dut_in sequence 000,001,011,010,110,111,101,100, each held 2 cycles; obs_table=0x53, pass=1.
